// File: rtl/tmp421_measure_fsm.sv
// tmp421_measure_fsm
//   Reads one TMP421 temperature channel (local or remote) through the
//   byte-level I2C master core. Each channel read is two pointer-write and
//   byte-read pairs (high byte, then low byte). The captured pair is
//   presented on Byte1_o/Byte0_o with a one-cycle Done_o strobe, or an
//   Error_o strobe if any transfer fails.
//
// Ports
//   Clk_i, Reset_n_i            clock, asynchronous active-low reset
//   QueryLocal_i/QueryRemote_i  one-cycle read requests (local wins on a tie)
//   Done_o / Error_o            one-cycle completion / failure strobes
//   Byte0_o / Byte1_o           low / high temperature byte
//   I2C_*                       control, TX data and RX handshake to the I2C core
//
// DataWidth must stay 8: the address and pointer bytes are fixed 8-bit values
// and the RX byte is stored without resizing.

module tmp421_measure_fsm #(
  parameter int         DataWidth  = 8,
  parameter logic [6:0] I2CAddress = 7'h4C
) (
  input  logic                 Clk_i,
  input  logic                 Reset_n_i,
  input  logic                 QueryLocal_i,
  input  logic                 QueryRemote_i,
  output logic                 Done_o,
  output logic                 Error_o,
  output logic [DataWidth-1:0] Byte0_o,
  output logic [DataWidth-1:0] Byte1_o,
  output logic                 I2C_ReceiveSend_n_o,
  output logic [3:0]           I2C_ReadCount_o,
  output logic                 I2C_StartProcess_o,
  input  logic                 I2C_Busy_i,
  output logic                 I2C_FIFOWrite_o,
  output logic [7:0]           I2C_Data_o,
  output logic                 I2C_FIFOReadNext_o,
  input  logic [7:0]           I2C_Data_i,
  input  logic                 I2C_Error_i
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_PTR   = 3'd1,
    ST_WAIT_WR  = 3'd2,
    ST_RD_START = 3'd3,
    ST_WAIT_RD  = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;      // 0 = local channel, 1 = remote channel
  logic                 phase_q, phase_d;  // 0 = high byte, 1 = low byte
  logic [DataWidth-1:0] byte0_q, byte0_d;
  logic [DataWidth-1:0] byte1_q, byte1_d;

  logic       fifo_write_s;
  logic [7:0] data_s;
  logic       start_s;
  logic       rs_n_s;
  logic [3:0] read_count_s;
  logic       read_next_s;
  logic       done_s;
  logic       error_s;

  logic [7:0] addr_wr_s;
  logic [7:0] addr_rd_s;
  logic [7:0] pointer_s;

  // Slave address bytes with the R/W bit appended, and the register pointer
  // (bit 4 picks the low-byte register, bit 0 picks the remote channel).
  assign addr_wr_s = {I2CAddress, 1'b0};
  assign addr_rd_s = {I2CAddress, 1'b1};
  assign pointer_s = {3'b000, phase_q, 3'b000, sel_q};

  // Next-state, capture and output decode for the measurement sequence.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    phase_d      = phase_q;
    byte0_d      = byte0_q;
    byte1_d      = byte1_q;
    fifo_write_s = 1'b0;
    data_s       = 8'h00;
    start_s      = 1'b0;
    rs_n_s       = 1'b0;
    read_count_s = 4'd0;
    read_next_s  = 1'b0;
    done_s       = 1'b0;
    error_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (QueryLocal_i || QueryRemote_i) begin
          // Address byte is pushed in the query cycle itself so the pointer
          // write can start on the very next cycle.
          sel_d        = ~QueryLocal_i;
          phase_d      = 1'b0;
          fifo_write_s = 1'b1;
          data_s       = addr_wr_s;
          state_d      = ST_WR_PTR;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_PTR: begin
        fifo_write_s = 1'b1;
        data_s       = pointer_s;
        start_s      = 1'b1;
        rs_n_s       = 1'b0;
        state_d      = ST_WAIT_WR;
      end

      ST_WAIT_WR: begin
        if (!I2C_Busy_i && I2C_Error_i) begin
          state_d = ST_ERR;
        end else if (!I2C_Busy_i) begin
          // Preload the read address while the core is idle.
          fifo_write_s = 1'b1;
          data_s       = addr_rd_s;
          state_d      = ST_RD_START;
        end else begin
          state_d = ST_WAIT_WR;
        end
      end

      ST_RD_START: begin
        start_s      = 1'b1;
        rs_n_s       = 1'b1;
        read_count_s = 4'd1;
        state_d      = ST_WAIT_RD;
      end

      ST_WAIT_RD: begin
        rs_n_s       = 1'b1;
        read_count_s = 4'd1;
        if (!I2C_Busy_i && I2C_Error_i) begin
          state_d = ST_ERR;
        end else if (!I2C_Busy_i) begin
          read_next_s = 1'b1;
          if (!phase_q) begin
            // High byte captured; chain straight into the low-byte pair.
            byte1_d      = I2C_Data_i;
            phase_d      = 1'b1;
            fifo_write_s = 1'b1;
            data_s       = addr_wr_s;
            state_d      = ST_WR_PTR;
          end else begin
            byte0_d = I2C_Data_i;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_WAIT_RD;
        end
      end

      ST_DONE: begin
        done_s  = 1'b1;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        error_s = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and captured temperature bytes.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      phase_q <= 1'b0;
      byte0_q <= '0;
      byte1_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      phase_q <= phase_d;
      byte0_q <= byte0_d;
      byte1_q <= byte1_d;
    end
  end

  assign Done_o              = done_s;
  assign Error_o             = error_s;
  assign Byte0_o             = byte0_q;
  assign Byte1_o             = byte1_q;
  assign I2C_ReceiveSend_n_o = rs_n_s;
  assign I2C_ReadCount_o     = read_count_s;
  assign I2C_StartProcess_o  = start_s;
  assign I2C_FIFOWrite_o     = fifo_write_s;
  assign I2C_Data_o          = data_s;
  assign I2C_FIFOReadNext_o  = read_next_s;

endmodule

// File: tb/tb_tmp421_measure_fsm.sv
// Self-checking bench for tmp421_measure_fsm: a small I2C core model answers
// transfers, expected TX bytes and results are queued when a query is driven
// and popped as the DUT produces them.

module tb_tmp421_measure_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       q_local, q_remote;
  logic       done_o, error_o;
  logic [7:0] byte0_o, byte1_o;
  logic       rs_n_o;
  logic [3:0] read_count_o;
  logic       start_o;
  logic       busy;
  logic       fifo_write_o;
  logic [7:0] data_o;
  logic       read_next_o;
  logic [7:0] rx_data;
  logic       i2c_err;

  always #5 clk = ~clk;

  tmp421_measure_fsm #(.DataWidth(8), .I2CAddress(7'h4C)) dut (
    .Clk_i               (clk),
    .Reset_n_i           (rst_n),
    .QueryLocal_i        (q_local),
    .QueryRemote_i       (q_remote),
    .Done_o              (done_o),
    .Error_o             (error_o),
    .Byte0_o             (byte0_o),
    .Byte1_o             (byte1_o),
    .I2C_ReceiveSend_n_o (rs_n_o),
    .I2C_ReadCount_o     (read_count_o),
    .I2C_StartProcess_o  (start_o),
    .I2C_Busy_i          (busy),
    .I2C_FIFOWrite_o     (fifo_write_o),
    .I2C_Data_o          (data_o),
    .I2C_FIFOReadNext_o  (read_next_o),
    .I2C_Data_i          (rx_data),
    .I2C_Error_i         (i2c_err)
  );

  typedef struct {
    logic       ql;
    logic       qr;
    logic       mid_qr;    // extra remote query pulsed mid-sequence
    logic [7:0] hi;        // model answer for pointer 0x00/0x01
    logic [7:0] lo;        // model answer for pointer 0x10/0x11
    int         err_mode;  // 0 none, 1 high-phase write, 2 low-phase read
    int         wr_d;
    int         rd_d;
    logic       exp_sel;
    logic       exp_err;
    logic [7:0] exp_b1;
    logic [7:0] exp_b0;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [7:0] b1;
    logic [7:0] b0;
  } res_t;

  logic [7:0] exp_tx[$];
  res_t       exp_res[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // I2C core model state
  int         busy_cnt = 0;
  logic       xfer_rd = 1'b0;
  logic [7:0] cur_ptr = 8'h00;
  logic [7:0] m_hi = 8'h00, m_lo = 8'h00;
  int         m_err_mode = 0, m_wr_d = 1, m_rd_d = 1;
  logic       smp_start = 1'b0, smp_rs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: sample DUT outputs mid-cycle and score them.
  always @(negedge clk) begin
    res_t       r;
    logic [7:0] t;
    smp_start = start_o;
    smp_rs    = rs_n_o;
    if (rst_n === 1'b1) begin
      if (done_o || error_o) begin
        check("strobe_exclusive", {31'd0, done_o & error_o}, 32'd0);
        if (exp_res.size() == 0) begin
          fail_now("unexpected_strobe");
        end else begin
          r = exp_res.pop_front();
          check("result_kind", {30'd0, error_o, done_o}, {30'd0, r.is_err, ~r.is_err});
          check("result_byte1", {24'd0, byte1_o}, {24'd0, r.b1});
          check("result_byte0", {24'd0, byte0_o}, {24'd0, r.b0});
        end
      end
      if (fifo_write_o) begin
        if (exp_tx.size() == 0) begin
          fail_now("unexpected_tx_write");
        end else begin
          t = exp_tx.pop_front();
          check("tx_byte", {24'd0, data_o}, {24'd0, t});
        end
        if (data_o != 8'h98 && data_o != 8'h99) cur_ptr = data_o;
      end
      if (start_o && rs_n_o) check("read_count", {28'd0, read_count_o}, 32'd1);
      if (read_next_o) check("read_next_mode", {27'd0, rs_n_o, read_count_o}, 32'h11);
    end
  end

  // I2C core model: busy from the cycle after a start, then error/data.
  always @(posedge clk) begin
    #1;
    if (rst_n !== 1'b1) begin
      busy     = 1'b0;
      busy_cnt = 0;
      i2c_err  = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          busy    = 1'b0;
          i2c_err = (m_err_mode == 1 && !xfer_rd && !cur_ptr[4]) ||
                    (m_err_mode == 2 &&  xfer_rd &&  cur_ptr[4]);
          if (xfer_rd) rx_data = cur_ptr[4] ? m_lo : m_hi;
        end
      end
      if (smp_start) begin
        busy     = 1'b1;
        i2c_err  = 1'b0;
        xfer_rd  = smp_rs;
        busy_cnt = smp_rs ? m_rd_d : m_wr_d;
      end
    end
  end

  task automatic start_query(input vec_t v);
    logic [7:0] p0, p1;
    res_t       r;
    m_hi       = v.hi;
    m_lo       = v.lo;
    m_err_mode = v.err_mode;
    m_wr_d     = v.wr_d;
    m_rd_d     = v.rd_d;
    p0 = {7'd0, v.exp_sel};
    p1 = {3'b000, 1'b1, 3'b000, v.exp_sel};
    exp_tx.push_back(8'h98);
    exp_tx.push_back(p0);
    if (v.err_mode != 1) begin
      exp_tx.push_back(8'h99);
      exp_tx.push_back(8'h98);
      exp_tx.push_back(p1);
      exp_tx.push_back(8'h99);
    end
    r.is_err = v.exp_err;
    r.b1     = v.exp_b1;
    r.b0     = v.exp_b0;
    exp_res.push_back(r);
    @(posedge clk); #1;
    q_local  = v.ql;
    q_remote = v.qr;
    @(negedge clk);
    check("first_write_same_cycle", {23'd0, fifo_write_o, data_o}, {23'd0, 1'b1, 8'h98});
    @(posedge clk); #1;
    q_local  = 1'b0;
    q_remote = 1'b0;
  endtask

  task automatic wait_result();
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_o || error_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail_now("result_timeout");
      exp_res.delete();
      exp_tx.delete();
    end
  endtask

  vec_t vecs[6];
  vec_t vr;

  initial begin
    bit found;
    // {ql, qr, mid_qr, hi, lo, err_mode, wr_d, rd_d, exp_sel, exp_err, exp_b1, exp_b0}
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h19, 8'h80, 0, 1, 1, 1'b0, 1'b0, 8'h19, 8'h80};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h2A, 8'h40, 0, 2, 1, 1'b1, 1'b0, 8'h2A, 8'h40};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h33, 8'h55, 0, 1, 3, 1'b0, 1'b0, 8'h33, 8'h55};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h77, 8'h66, 1, 2, 1, 1'b0, 1'b1, 8'h33, 8'h55};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h5A, 8'hA5, 2, 1, 2, 1'b1, 1'b1, 8'h5A, 8'h55};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'hFF, 0, 3, 4, 1'b0, 1'b0, 8'h01, 8'hFF};

    rst_n    = 1'b0;
    q_local  = 1'b0;
    q_remote = 1'b0;
    busy     = 1'b0;
    i2c_err  = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_strobes", {30'd0, done_o, error_o}, 32'd0);
    check("reset_bytes", {16'd0, byte1_o, byte0_o}, 32'd0);
    check("reset_i2c_ctrl", {24'd0, fifo_write_o, start_o, read_next_o, rs_n_o, read_count_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Each vector starts in the cycle right after the previous strobe.
    for (int i = 0; i < 6; i++) begin
      start_query(vecs[i]);
      if (vecs[i].mid_qr) begin
        repeat (2) @(posedge clk);
        #1 q_remote = 1'b1;
        @(posedge clk);
        #1 q_remote = 1'b0;
      end
      wait_result();
    end

    repeat (20) @(negedge clk);
    check("tx_queue_drained", exp_tx.size(), 32'd0);
    check("result_queue_drained", exp_res.size(), 32'd0);

    // Reset during the low-phase read.
    vr = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 0, 2, 20, 1'b0, 1'b0, 8'h12, 8'h34};
    start_query(vr);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && busy) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("low_read_reached");
    repeat (3) @(posedge clk);
    check("pre_reset_byte1", {24'd0, byte1_o}, 32'h12);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_strobes", {30'd0, done_o, error_o}, 32'd0);
    check("mid_reset_bytes", {16'd0, byte1_o, byte0_o}, 32'd0);
    check("mid_reset_i2c_ctrl", {24'd0, fifo_write_o, start_o, read_next_o, rs_n_o, read_count_o}, 32'd0);
    check("mid_reset_data", {24'd0, data_o}, 32'd0);
    exp_res.delete();
    exp_tx.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    vr = '{1'b0, 1'b1, 1'b0, 8'h44, 8'h22, 0, 1, 1, 1'b1, 1'b0, 8'h44, 8'h22};
    start_query(vr);
    wait_result();
    repeat (10) @(negedge clk);
    check("final_queues_drained", exp_tx.size() + exp_res.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
